// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stage registers and debug readout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: skid-register state enum, stage payload widths, debug chunk width,
// and a helper that sizes the debug chunk counter.
package mips_pkg;

  // Occupancy of a stage register: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

  // Payload widths of each pipeline boundary.
  localparam int IF_ID_W  = 32;
  localparam int ID_EX_W  = 129;
  localparam int EX_MEM_W = 77;
  localparam int MEM_WB_W = 71;

  // Chunk width used by the UART debugger readout.
  localparam int DBG_BYTE_W = 8;

  // Number of BYTE_W chunks needed to cover a payload of the given width.
  function automatic int num_chunks(input int data_w, input int byte_w);
    return (data_w + byte_w - 1) / byte_w;
  endfunction

endpackage

// File: rtl/pipeline_reg_skid_snapshot.sv
// Debug shadow of a wide register, read back one BYTE_W chunk per request.
// Latency: o_rd_byte/o_rd_last registered, valid 1 cycle after i_snap/i_rd_next.
// Backpressure: none; i_snap while busy and i_rd_next while idle are ignored.
// Ports: i_clk, i_rst_n (async, active low); i_snap + i_snap_data load the shadow;
// i_rd_next advances the chunk index; o_rd_byte current chunk, o_rd_last final
// chunk flag, o_snap_busy shadow holds an unread snapshot.
module stage_snapshot
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 129,
  parameter int BYTE_W     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_snap,
  input  logic [DATA_WIDTH-1:0] i_snap_data,
  input  logic                  i_rd_next,
  output logic [BYTE_W-1:0]     o_rd_byte,
  output logic                  o_rd_last,
  output logic                  o_snap_busy
);

  localparam int NUM_CHUNKS = num_chunks(DATA_WIDTH, BYTE_W);
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int PAD_W      = NUM_CHUNKS * BYTE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  logic [PAD_W-1:0]  shadow_q, shadow_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              last_q, last_d;
  logic [PAD_W-1:0]  snap_pad;

  // Zero-extend the payload so the top chunk reads 0 above DATA_WIDTH.
  always_comb begin
    snap_pad                 = '0;
    snap_pad[DATA_WIDTH-1:0] = i_snap_data;
  end

  always_comb begin
    shadow_d = shadow_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    if (i_snap && !busy_q) begin
      shadow_d = snap_pad;
      idx_d    = '0;
      busy_d   = 1'b1;
    end else if (i_rd_next && busy_q) begin
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        busy_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // The readout registers are computed from next-state values so the chunk
  // selected by this cycle's request is visible on the following cycle.
  always_comb begin
    byte_d = '0;
    last_d = 1'b0;
    if (busy_d) begin
      for (int c = 0; c < NUM_CHUNKS; c++) begin
        if (idx_d == IDX_W'(c)) begin
          byte_d = shadow_d[c*BYTE_W +: BYTE_W];
        end
      end
      last_d = (idx_d == LAST_IDX);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      byte_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
    end
  end

  assign o_rd_byte   = byte_q;
  assign o_rd_last   = last_q;
  assign o_snap_busy = busy_q;

endmodule

// File: rtl/pipeline_reg_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid, flush, bubble and debug snapshot.
// Latency: 1 cycle push to o_valid/o_data; skid entry reaches o_data 1 cycle after the draining pop.
// Backpressure: o_ready low when skid is occupied or i_bubble is high; full throughput otherwise.
// Ports: i_clk, i_rst_n (async, active low); upstream i_valid/o_ready/i_data;
// downstream o_valid/i_ready/o_data; i_flush squash; i_bubble stall upstream;
// debug i_snap, i_rd_next, o_rd_byte, o_rd_last, o_snap_busy.
module pipeline_reg_skid
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = 129,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int BYTE_W         = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_flush,
  input  logic                  i_bubble,
  input  logic                  i_snap,
  input  logic                  i_rd_next,
  output logic [BYTE_W-1:0]     o_rd_byte,
  output logic                  o_rd_last,
  output logic                  o_snap_busy
);

  skid_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  push, pop;

  // ---------------------------------------------------------------------
  // Output decode: everything except the bubble term comes from state_q.
  // ---------------------------------------------------------------------
  always_comb begin
    o_ready = (state_q != SKID) && !i_bubble;
    o_valid = (state_q != EMPTY);
  end

  assign push   = i_valid && o_ready;
  assign pop    = o_valid && i_ready;
  assign o_data = main_q;

  // ---------------------------------------------------------------------
  // Next-state logic. Flush overrides any simultaneous push/pop.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (push) state_d = FULL;
        FULL: begin
          if (push && !pop)      state_d = SKID;
          else if (!push && pop) state_d = EMPTY;
        end
        // o_ready is low here, so only a pop can happen.
        SKID: if (pop) state_d = FULL;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Data path. Main only reloads when it is free or being drained, so a
  // push that lands while downstream stalls is parked in skid instead.
  // ---------------------------------------------------------------------
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (i_flush) begin
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: if (push) main_d = i_data;
        FULL: begin
          if (push && pop)  main_d = i_data;
          else if (push)    skid_d = i_data;
        end
        SKID: if (pop) main_d = skid_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Debug shadow samples the main register, independent of handshake/flush.
  stage_snapshot #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_W     (BYTE_W)
  ) u_snapshot (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_snap      (i_snap),
    .i_snap_data (main_q),
    .i_rd_next   (i_rd_next),
    .o_rd_byte   (o_rd_byte),
    .o_rd_last   (o_rd_last),
    .o_snap_busy (o_snap_busy)
  );

endmodule
